// File: rtl/block_state_ctrl_pkg.sv
// Shared constants and state encoding for the brick-wall controller.
// blocks_drawer uses the same geometry constants.
package block_state_ctrl_pkg;

    localparam int BLOCKS_PER_ROW = 13;
    localparam int NUM_ROWS       = 16;
    localparam int NUM_BLOCKS     = BLOCKS_PER_ROW * NUM_ROWS;
    localparam int IDX_W          = 8;
    localparam int ROW_W          = $clog2(NUM_ROWS);
    localparam int CNT_W          = $clog2(BLOCKS_PER_ROW + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_LOAD       = 2'd2
    } state_t;

    // A hit is live only for an in-range index whose brick is still present.
    function automatic logic brick_live(input logic [NUM_BLOCKS-1:0] bs,
                                        input logic [IDX_W-1:0]      idx);
        logic live;
        live = 1'b0;
        if (idx < IDX_W'(NUM_BLOCKS))
            live = bs[idx];
        return live;
    endfunction

endpackage

// File: rtl/block_state_ctrl_if.sv
// Hit-request handshake between the two collision probes and the controller.
interface block_state_ctrl_if;
    import block_state_ctrl_pkg::*;

    logic             hit_req_a;
    logic             hit_req_b;
    logic [IDX_W-1:0] hit_idx_a;
    logic [IDX_W-1:0] hit_idx_b;
    logic             hit_ack_a;
    logic             hit_ack_b;
    logic             hit_live_a;
    logic             hit_live_b;

    // Game logic side: raises requests, holds index until acked.
    modport master (
        output hit_req_a, hit_req_b, hit_idx_a, hit_idx_b,
        input  hit_ack_a, hit_ack_b, hit_live_a, hit_live_b
    );

    // Controller side.
    modport slave (
        input  hit_req_a, hit_req_b, hit_idx_a, hit_idx_b,
        output hit_ack_a, hit_ack_b, hit_live_a, hit_live_b
    );
endinterface

// File: rtl/block_state_ctrl_popcount13.sv
// Combinational population count of one brick row.
module popcount13
    import block_state_ctrl_pkg::*;
(
    input  logic [BLOCKS_PER_ROW-1:0] bits,
    output logic [CNT_W-1:0]          count
);
    // Sum the set bits of the row mask.
    always_comb begin
        count = '0;
        for (int i = 0; i < BLOCKS_PER_ROW; i++)
            count = count + CNT_W'(bits[i]);
    end
endmodule

// File: rtl/block_state_ctrl.sv
// Brick-wall occupancy owner: frame-aligned level load, two-probe hit
// arbitration with round-robin, bricks-left tracking and level-clear pulse.
module block_state_ctrl
    import block_state_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      new_frame,
    input  logic                      load_level,
    output logic [ROW_W-1:0]          pattern_row,
    input  logic [BLOCKS_PER_ROW-1:0] pattern_bits,
    block_state_ctrl_if.slave         hit,
    output logic [NUM_BLOCKS-1:0]     block_state,
    output logic [IDX_W-1:0]          blocks_left,
    output logic                      level_clear,
    output logic                      busy
);
    state_t                state_q, state_n;
    logic [ROW_W-1:0]      row_q, row_n;
    logic [NUM_BLOCKS-1:0] bs_q, bs_n;
    logic [IDX_W-1:0]      left_q, left_n;
    logic                  ack_a_q, ack_a_n, ack_b_q, ack_b_n;
    logic                  live_a_q, live_a_n, live_b_q, live_b_n;
    logic                  clr_q, clr_n;
    logic                  rr_q, rr_n;     // 0 favours A, 1 favours B

    logic                  elig_a, elig_b, both;
    logic                  grant_a, grant_b, grant_live;
    logic [IDX_W-1:0]      grant_idx;
    logic [CNT_W-1:0]      row_count;

    popcount13 u_popcount (
        .bits  (pattern_bits),
        .count (row_count)
    );

    // State and datapath registers; reset aborts any load or grant.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            bs_q     <= '0;
            left_q   <= '0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            live_a_q <= 1'b0;
            live_b_q <= 1'b0;
            clr_q    <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            row_q    <= row_n;
            bs_q     <= bs_n;
            left_q   <= left_n;
            ack_a_q  <= ack_a_n;
            ack_b_q  <= ack_b_n;
            live_a_q <= live_a_n;
            live_b_q <= live_b_n;
            clr_q    <= clr_n;
            rr_q     <= rr_n;
        end
    end

    // Arbitration: a port whose ack is showing this cycle is not eligible,
    // so a still-held request cannot be granted twice.
    always_comb begin
        elig_a     = hit.hit_req_a && !ack_a_q && (state_q == ST_IDLE);
        elig_b     = hit.hit_req_b && !ack_b_q && (state_q == ST_IDLE);
        both       = elig_a && elig_b;
        grant_a    = elig_a && (!elig_b || !rr_q);
        grant_b    = elig_b && !grant_a;
        grant_idx  = grant_a ? hit.hit_idx_a : hit.hit_idx_b;
        grant_live = (grant_a || grant_b) && brick_live(bs_q, grant_idx);
    end

    // Next-state and register updates for load sequencing and hits.
    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        bs_n     = bs_q;
        left_n   = left_q;
        ack_a_n  = 1'b0;
        ack_b_n  = 1'b0;
        live_a_n = 1'b0;
        live_b_n = 1'b0;
        clr_n    = 1'b0;
        rr_n     = rr_q;
        case (state_q)
            ST_IDLE: begin
                ack_a_n  = grant_a;
                ack_b_n  = grant_b;
                live_a_n = grant_a && grant_live;
                live_b_n = grant_b && grant_live;
                if (both)
                    rr_n = grant_a;
                if (grant_live) begin
                    bs_n[grant_idx] = 1'b0;
                    left_n          = left_q - IDX_W'(1);
                    clr_n           = (left_q == IDX_W'(1));
                end
                if (load_level)
                    state_n = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (new_frame) begin
                    state_n = ST_LOAD;
                    row_n   = '0;
                    bs_n    = '0;
                    left_n  = '0;
                end
            end
            ST_LOAD: begin
                bs_n[row_q*BLOCKS_PER_ROW +: BLOCKS_PER_ROW] = pattern_bits;
                left_n = left_q + IDX_W'(row_count);
                row_n  = row_q + ROW_W'(1);
                if (row_q == ROW_W'(NUM_ROWS - 1))
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pattern_row    = row_q;
    assign block_state    = bs_q;
    assign blocks_left    = left_q;
    assign level_clear    = clr_q;
    assign busy           = (state_q != ST_IDLE);
    assign hit.hit_ack_a  = ack_a_q;
    assign hit.hit_ack_b  = ack_b_q;
    assign hit.hit_live_a = live_a_q;
    assign hit.hit_live_b = live_b_q;

endmodule

// File: tb/tb_block_state_ctrl.sv
// Bench for block_state_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the wall.
module tb_block_state_ctrl;
    logic         clk;
    logic         nRst;
    logic         new_frame;
    logic         load_level;
    logic [3:0]   pattern_row;
    logic [12:0]  pattern_bits;
    logic [207:0] block_state;
    logic [7:0]   blocks_left;
    logic         level_clear;
    logic         busy;

    logic [12:0]  rom [16];
    int           checks = 0;
    int           errors = 0;

    block_state_ctrl_if hif();

    block_state_ctrl dut (
        .clk          (clk),
        .nRst         (nRst),
        .new_frame    (new_frame),
        .load_level   (load_level),
        .pattern_row  (pattern_row),
        .pattern_bits (pattern_bits),
        .hit          (hif),
        .block_state  (block_state),
        .blocks_left  (blocks_left),
        .level_clear  (level_clear),
        .busy         (busy)
    );

    assign pattern_bits = rom[pattern_row];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: wall as a bit vector, mode = idle/wait/load.
    logic [207:0] m_bs = '0;
    int           m_mode = 0;
    int           m_row = 0;
    bit           m_ptr_b = 1'b0;
    bit           e_ack_a = 1'b0, e_ack_b = 1'b0;
    bit           e_live_a = 1'b0, e_live_b = 1'b0, e_clr = 1'b0;

    initial begin
        bit na, nb, ea, eb, live;
        int gi;
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                m_bs = '0; m_mode = 0; m_row = 0; m_ptr_b = 1'b0;
                e_ack_a = 1'b0; e_ack_b = 1'b0;
                e_live_a = 1'b0; e_live_b = 1'b0; e_clr = 1'b0;
            end else begin
                na = 1'b0; nb = 1'b0; live = 1'b0; e_clr = 1'b0; gi = 0;
                case (m_mode)
                    0: begin
                        ea = hif.hit_req_a && !e_ack_a;
                        eb = hif.hit_req_b && !e_ack_b;
                        if (ea && (!eb || !m_ptr_b)) begin
                            na = 1'b1; gi = int'(hif.hit_idx_a);
                            if (eb) m_ptr_b = 1'b1;
                        end else if (eb) begin
                            nb = 1'b1; gi = int'(hif.hit_idx_b);
                            if (ea) m_ptr_b = 1'b0;
                        end
                        if ((na || nb) && gi < 208) begin
                            live = m_bs[gi];
                            if (live) begin
                                m_bs[gi] = 1'b0;
                                e_clr = ($countones(m_bs) == 0);
                            end
                        end
                        if (load_level) m_mode = 1;
                    end
                    1: if (new_frame) begin
                        m_mode = 2; m_row = 0; m_bs = '0;
                    end
                    default: begin
                        m_bs[m_row*13 +: 13] = rom[m_row];
                        m_row = m_row + 1;
                        if (m_row == 16) begin m_mode = 0; m_row = 0; end
                    end
                endcase
                e_ack_a = na; e_ack_b = nb;
                e_live_a = na && live; e_live_b = nb && live;
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("m_block_state", block_state, m_bs);
        chk("m_blocks_left", blocks_left, 256'($countones(m_bs)));
        chk("m_busy", busy, m_mode != 0);
        chk("m_pattern_row", pattern_row, m_row[3:0]);
        chk("m_ack_a", hif.hit_ack_a, e_ack_a);
        chk("m_ack_b", hif.hit_ack_b, e_ack_b);
        chk("m_level_clear", level_clear, e_clr);
        if (e_ack_a) chk("m_live_a", hif.hit_live_a, e_live_a);
        if (e_ack_b) chk("m_live_b", hif.hit_live_b, e_live_b);
    endtask

    // Advance to the next falling edge, compare, and retire acked requests.
    task automatic step();
        @(negedge clk);
        compare_all();
        if (hif.hit_ack_a) hif.hit_req_a = 1'b0;
        if (hif.hit_ack_b) hif.hit_req_b = 1'b0;
    endtask

    // Request a load, pulse new_frame, and count busy/ack cycles during LOAD.
    task automatic do_load(input bit with_req, output int acks_seen);
        int nb;
        load_level = 1'b1;
        step();
        load_level = 1'b0;
        if (with_req) begin
            hif.hit_req_a = 1'b1;
            hif.hit_idx_a = 8'd30;
        end
        step();
        acks_seen = hif.hit_ack_a ? 1 : 0;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        nb = 0;
        repeat (16) begin
            if (busy) nb++;
            if (hif.hit_ack_a) acks_seen++;
            step();
        end
        chk("busy_16_cycles", 256'(nb), 256'd16);
        chk("busy_after_load", busy, 1'b0);
    endtask

    initial begin
        int acks, nclr;
        nRst = 1'b0; new_frame = 1'b0; load_level = 1'b0;
        hif.hit_req_a = 1'b0; hif.hit_req_b = 1'b0;
        hif.hit_idx_a = '0; hif.hit_idx_b = '0;
        for (int r = 0; r < 16; r++) rom[r] = 13'h1FFF;
        repeat (3) @(negedge clk);
        chk("rst_block_state", block_state, 256'd0);
        chk("rst_blocks_left", blocks_left, 256'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {hif.hit_ack_a, hif.hit_ack_b, level_clear}, 3'b000);
        chk("rst_pattern_row", pattern_row, 4'd0);
        nRst = 1'b1;
        step();

        // Full wall
        do_load(1'b0, acks);
        chk("full_block_state", block_state, {48'd0, {208{1'b1}}});
        chk("full_blocks_left", blocks_left, 8'd208);

        // Single hit, then repeat on the same brick
        hif.hit_req_a = 1'b1; hif.hit_idx_a = 8'd0;
        step();
        chk("hit0_ack", hif.hit_ack_a, 1'b1);
        chk("hit0_live", hif.hit_live_a, 1'b1);
        chk("hit0_bit", block_state[0], 1'b0);
        chk("hit0_left", blocks_left, 8'd207);
        step();
        hif.hit_req_a = 1'b1; hif.hit_idx_a = 8'd0;
        step();
        chk("rehit0_ack", hif.hit_ack_a, 1'b1);
        chk("rehit0_live", hif.hit_live_a, 1'b0);
        chk("rehit0_left", blocks_left, 8'd207);
        step();

        // Collision on idx 14, pointer on A
        hif.hit_req_a = 1'b1; hif.hit_idx_a = 8'd14;
        hif.hit_req_b = 1'b1; hif.hit_idx_b = 8'd14;
        step();
        chk("coll_c1", {hif.hit_ack_a, hif.hit_live_a, hif.hit_ack_b}, 3'b110);
        step();
        chk("coll_c2", {hif.hit_ack_a, hif.hit_ack_b, hif.hit_live_b}, 3'b010);
        step();
        chk("coll_c3", {hif.hit_ack_a, hif.hit_ack_b}, 2'b00);
        chk("coll_left", blocks_left, 8'd206);

        // Out-of-range index
        hif.hit_req_b = 1'b1; hif.hit_idx_b = 8'd208;
        step();
        chk("bad_ack", {hif.hit_ack_b, hif.hit_live_b}, 2'b10);
        chk("bad_left", blocks_left, 8'd206);
        step();

        // Request held across WAIT_FRAME/LOAD is granted only after LOAD
        do_load(1'b1, acks);
        chk("held_no_ack", 256'(acks), 256'd0);
        step();
        chk("held_ack", {hif.hit_ack_a, hif.hit_live_a}, 2'b11);
        chk("held_left", blocks_left, 8'd207);
        step();

        // Empty pattern: no level_clear from a load
        for (int r = 0; r < 16; r++) rom[r] = 13'h0000;
        do_load(1'b0, acks);
        chk("empty_left", blocks_left, 8'd0);

        // Last brick
        rom[0] = 13'h0020;
        do_load(1'b0, acks);
        chk("last_left_pre", blocks_left, 8'd1);
        hif.hit_req_a = 1'b1; hif.hit_idx_a = 8'd5;
        nclr = 0;
        step();
        chk("last_live", {hif.hit_ack_a, hif.hit_live_a}, 2'b11);
        chk("last_left", blocks_left, 8'd0);
        if (level_clear) nclr++;
        repeat (3) begin
            step();
            if (level_clear) nclr++;
        end
        chk("last_clear_once", 256'(nclr), 256'd1);

        // Reset at LOAD row 7
        for (int r = 0; r < 16; r++) rom[r] = 13'h1FFF;
        load_level = 1'b1; step(); load_level = 1'b0;
        step();
        new_frame = 1'b1; step(); new_frame = 1'b0;
        repeat (7) step();
        chk("midload_row", pattern_row, 4'd7);
        chk("midload_busy", busy, 1'b1);
        nRst = 1'b0;
        #1;
        chk("midrst_state", {block_state, blocks_left, pattern_row, busy}, 256'd0);
        step();
        nRst = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (c % 800 == 0)
                for (int r = 0; r < 16; r++)
                    rom[r] = 13'($urandom) & 13'($urandom) & (((c / 800) % 2 == 1) ? 13'h0003 : 13'h1FFF);
            load_level = ($urandom_range(0, 79) == 0);
            new_frame  = ($urandom_range(0, 9) == 0);
            if (!hif.hit_req_a && $urandom_range(0, 2) == 0) begin
                hif.hit_req_a = 1'b1;
                hif.hit_idx_a = 8'($urandom_range(0, 215));
            end
            if (!hif.hit_req_b && $urandom_range(0, 2) == 0) begin
                hif.hit_req_b = 1'b1;
                hif.hit_idx_b = ($urandom_range(0, 3) == 0) ? hif.hit_idx_a
                                                           : 8'($urandom_range(0, 215));
            end
            step();
        end
        load_level = 1'b0; new_frame = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
